// File: rtl/imm_encoder.sv
// imm_encoder: two-stage RV32I immediate encoder.
// Takes a signed immediate, a format select (ImmSrc) and a template instruction.
// It scatters the immediate into the I/S/B/U/J field positions and flags range,
// alignment and format violations for each item.
// Valid/ready stream in and out, with two-cycle latency and one item per cycle.
// Optional build macro: IMM_ENCODER_SELFCHECK_EN. When it is defined, stage 2
// re-decodes each packed instruction and raises a sticky selfcheck_err if the
// decoded value differs from the captured immediate on an error-free item.
module imm_encoder #(
    parameter int DATA_WIDTH = 32,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [2:0]            ImmSrc,
    input  logic [DATA_WIDTH-1:0] base_instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic [2:0]            err,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic                  selfcheck_err
);

    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_S = 3'b001;
    localparam logic [2:0] SRC_B = 3'b010;
    localparam logic [2:0] SRC_U = 3'b011;
    localparam logic [2:0] SRC_J = 3'b100;

    // Lowest bit of the sign-extension region for each range-checked format:
    // index 0 = I/S (12-bit), 1 = B (13-bit), 2 = J (21-bit).
    localparam int RANGE_LOW [3] = '{11, 12, 20};

    // Stage 1 state
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_imm;
    logic [2:0]            s1_src;
    logic [DATA_WIDTH-1:0] s1_base;
    logic [2:0]            s1_err;

    // Stage 2 state
    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] instr_reg;
    logic [2:0]            err_reg;
    logic [ERR_CNT_W-1:0]  err_count_reg;

    // Handshake and combinational helpers
    logic                  s2_load;
    logic [2:0]            upper_fits;
    logic [2:0]            in_err;
    logic [DATA_WIDTH-1:0] packed_instr;

    // Stage 2 takes a new item whenever it is empty or its item is leaving;
    // stage 1 advances on the same condition, so a full pipe streams freely.
    assign s2_load  = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;

    assign out_valid = s2_valid;
    assign instr_out = instr_reg;
    assign err       = err_reg;
    assign err_count = err_count_reg;

    // An immediate fits a format when every bit from the format's sign bit
    // upward is identical (all zeros or all ones).
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_range
            assign upper_fits[gi] = (&imm[DATA_WIDTH-1:RANGE_LOW[gi]]) |
                                    ~(|imm[DATA_WIDTH-1:RANGE_LOW[gi]]);
        end
    endgenerate

    // Classify the incoming item: err = {fmt_err, align_err, range_err}.
    always_comb begin
        in_err = 3'b000;
        case (ImmSrc)
            SRC_I, SRC_S: begin
                in_err[0] = !upper_fits[0];
            end
            SRC_B: begin
                in_err[0] = !upper_fits[1];
                in_err[1] = imm[0];
            end
            SRC_U: begin
                in_err[1] = |imm[11:0];
            end
            SRC_J: begin
                in_err[0] = !upper_fits[2];
                in_err[1] = imm[0];
            end
            default: begin
                in_err[2] = 1'b1;
            end
        endcase
    end

    // Stage 1: capture the item and its error flags when the pipe can advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_imm   <= '0;
            s1_src   <= '0;
            s1_base  <= '0;
            s1_err   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_imm  <= imm;
                s1_src  <= ImmSrc;
                s1_base <= base_instr;
                s1_err  <= in_err;
            end
        end
    end

    // Scatter the captured immediate into the template. Out-of-range
    // immediates simply lose their upper bits; illegal formats pass the
    // template through untouched.
    always_comb begin
        packed_instr = s1_base;
        case (s1_src)
            SRC_I: begin
                packed_instr[31:20] = s1_imm[11:0];
            end
            SRC_S: begin
                packed_instr[31:25] = s1_imm[11:5];
                packed_instr[11:7]  = s1_imm[4:0];
            end
            SRC_B: begin
                packed_instr[31]    = s1_imm[12];
                packed_instr[30:25] = s1_imm[10:5];
                packed_instr[11:8]  = s1_imm[4:1];
                packed_instr[7]     = s1_imm[11];
            end
            SRC_U: begin
                packed_instr[31:12] = s1_imm[31:12];
            end
            SRC_J: begin
                packed_instr[31]    = s1_imm[20];
                packed_instr[30:21] = s1_imm[10:1];
                packed_instr[20]    = s1_imm[11];
                packed_instr[19:12] = s1_imm[19:12];
            end
            default: begin
            end
        endcase
    end

    // Stage 2: output register. Data only changes when a real item arrives,
    // so instr_out/err stay put while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            instr_reg <= '0;
            err_reg   <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                instr_reg <= packed_instr;
                err_reg   <= s1_err;
            end
        end
    end

    // Count delivered items that carry any error flag; hold at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count_reg <= '0;
        end else if (s2_valid && out_ready && (err_reg != 3'b000) && !(&err_count_reg)) begin
            err_count_reg <= err_count_reg + 1'b1;
        end
    end

`ifdef IMM_ENCODER_SELFCHECK_EN
    logic [DATA_WIDTH-1:0] decoded;
    logic                  mismatch;
    logic                  selfcheck_reg;

    // Re-decode the packed word exactly as the core does (sign-extended,
    // B/J with an implied zero LSB) and compare against the original.
    always_comb begin
        decoded = '0;
        case (s1_src)
            SRC_I: decoded = {{20{packed_instr[31]}}, packed_instr[31:20]};
            SRC_S: decoded = {{20{packed_instr[31]}}, packed_instr[31:25], packed_instr[11:7]};
            SRC_B: decoded = {{19{packed_instr[31]}}, packed_instr[31], packed_instr[7],
                              packed_instr[30:25], packed_instr[11:8], 1'b0};
            SRC_U: decoded = {packed_instr[31:12], 12'b0};
            SRC_J: decoded = {{11{packed_instr[31]}}, packed_instr[31], packed_instr[19:12],
                              packed_instr[20], packed_instr[30:21], 1'b0};
            default: decoded = '0;
        endcase
        mismatch = s1_valid && (s1_err == 3'b000) && (decoded != s1_imm);
    end

    // Sticky flag, loaded alongside the stage 2 item it describes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            selfcheck_reg <= 1'b0;
        end else if (s2_load && mismatch) begin
            selfcheck_reg <= 1'b1;
        end
    end

    assign selfcheck_err = selfcheck_reg;
`else
    assign selfcheck_err = 1'b0;
`endif

endmodule
